// File: rtl/hms_display_scan_pkg.sv
// Shared constants for the six-digit H.M.S multiplexed 7-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package hms_display_scan_pkg;

  localparam int DIGIT_W = 3;
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = 3'd5;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  localparam logic [5:0] AN_OFF = 6'b111111;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2
  } field_e;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

endpackage

// File: rtl/hms_display_scan_seg7_encode.sv
// Combinational 4-bit code to active-low 7-segment pattern, with a dash override.
module seg7_encode
  import hms_display_scan_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/hms_display_scan.sv
// Six-digit multiplexed scanner for an H.M.S stopwatch; the time is snapshotted
// once per frame so the scan never shows a mix of old and new values.
module hms_display_scan
  import hms_display_scan_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [4:0] hour_i,
  input  logic       blank_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0]   pre_cnt;
  logic [PRE_W-1:0]   pre_next;
  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] digit_next;
  hms_t               snap;
  hms_t               snap_next;
  logic               tick;
  logic               frame_wrap;

  field_e     field_sel;
  logic [5:0] field_val;
  logic       field_dash;
  logic [3:0] field_tens;
  logic [3:0] field_units;
  logic [3:0] digit_code;
  logic [6:0] enc_seg;

  assign tick       = (pre_cnt == PRE_W'(CLK_DIV - 1));
  assign frame_wrap = tick && (digit == LAST_DIGIT);
  assign pre_next   = tick ? '0 : pre_cnt + 1'b1;

  always_comb begin
    digit_next = digit;
    if (tick) begin
      digit_next = (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
    end
  end

  // The frame-boundary tick must already encode digit 0 from the fresh sample.
  always_comb begin
    snap_next = snap;
    if (frame_wrap) begin
      snap_next.sec  = sec_i;
      snap_next.min  = min_i;
      snap_next.hour = hour_i;
    end
  end

  always_comb begin
    field_sel  = field_e'(digit_next[2:1]);
    field_val  = '0;
    field_dash = 1'b0;
    case (field_sel)
      FIELD_SEC: begin
        field_val  = snap_next.sec;
        field_dash = (snap_next.sec > SEC_MAX);
      end
      FIELD_MIN: begin
        field_val  = snap_next.min;
        field_dash = (snap_next.min > MIN_MAX);
      end
      default: begin
        field_val  = {1'b0, snap_next.hour};
        field_dash = (snap_next.hour > HOUR_MAX);
      end
    endcase
    field_tens  = 4'(field_val / 6'd10);
    field_units = 4'(field_val % 6'd10);
    digit_code  = digit_next[0] ? field_tens : field_units;
  end

  seg7_encode u_seg7_encode (
    .code (digit_code),
    .dash (field_dash),
    .seg  (enc_seg)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pre_cnt <= '0;
      digit   <= '0;
      snap    <= '0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      digit   <= digit_next;
      snap    <= snap_next;
      frame_o <= frame_wrap;
      if (blank_i || (pre_next < PRE_W'(BLANK_CYC))) begin
        an_o <= AN_OFF;
      end else begin
        an_o <= ~(6'b000001 << digit_next);
      end
      if (tick) begin
        seg_o <= enc_seg;
        dp_o  <= !((digit_next == 3'd2) || (digit_next == 3'd4));
      end
    end
  end

endmodule

// File: doc/hms_display_scan.md
HMS_DISPLAY_SCAN -- requirements
Module: hms_display_scan

Interface
REQ-001 Parameter CLK_DIV, default 1000, clock cycles per digit slot (legal range 4..65535).
REQ-002 Parameter BLANK_CYC, default 2, cycles at the start of each slot with all anodes off (legal range 0..CLK_DIV-2).
REQ-003 Port clk_i  input  1  single system clock; all state rises on its posedge.
REQ-004 Port reset_i  input  1  asynchronous, active-high reset.
REQ-005 Port sec_i  input  6  binary seconds from the stopwatch (legal 0..59).
REQ-006 Port min_i  input  6  binary minutes from the stopwatch (legal 0..59).
REQ-007 Port hour_i  input  5  binary hours from the stopwatch (legal 0..23).
REQ-008 Port blank_i  input  1  level; 1 forces all anodes off.
REQ-009 Port an_o  output  6  active-low digit enables; bit0 = seconds units, bit5 = hours tens.
REQ-010 Port seg_o  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 Port dp_o  output  1  active-low decimal point; lit on digits 2 and 4 (H.M separators).
REQ-012 Port frame_o  output  1  one-cycle pulse when a new snapshot is taken.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps to 0; the wrap cycle is the slot tick.
REQ-014 Digit index counts 0..5 and advances by 1 on each slot tick; from 5 it wraps to 0.
REQ-015 On the tick that takes the digit index from 5 to 0, register sec_i/min_i/hour_i into a snapshot and pulse frame_o for that cycle.
REQ-016 All displayed digits come from the snapshot only, so input changes mid-frame never tear the display.
REQ-017 Each field is split into tens = value/10 and units = value%10, computed from the snapshot.
REQ-018 A field above its legal maximum (sec/min > 59, hour > 23) shows a dash (segment g only) on both of its digits.
REQ-019 Segment patterns are the standard 0..9 codes (0 = a,b,c,d,e,f); an illegal BCD code shows all segments off.
REQ-020 During prescaler counts 0..BLANK_CYC-1, an_o = 6'b111111; otherwise an_o is low on the current digit bit only.
REQ-021 seg_o and dp_o are registered and change only on the slot tick, so they are stable during the whole slot.
REQ-022 When blank_i = 1, an_o = 6'b111111 in the next cycle; counters keep running and snapshots continue.
REQ-023 Output latency from the snapshot to the first lit digit 0 is BLANK_CYC+1 cycles.

Reset
REQ-024 On reset_i, the following are cleared asynchronously: prescaler = 0, digit index = 0, snapshot = 0, an_o = 6'b111111, seg_o = 7'b1111111, dp_o = 1, frame_o = 0.
REQ-025 After reset_i deasserts, the first snapshot is taken on the first wrap of digit 5 to 0 (6*CLK_DIV cycles later).
REQ-026 Until the first snapshot, the display shows "00.00.00".
REQ-027 Reset asserted mid-slot aborts the scan immediately; no partial frame_o pulse is produced.

Structure
REQ-028 A shared package holds the 7-segment code constants (digits 0..9, dash, off), the digit-index width, and the field maximum constants 59 and 23.
REQ-029 One sub-module, seg7_encode, maps a 4-bit code plus a dash flag to seg_o; it is purely combinational.
REQ-030 The divide-by-10 split is combinational within the top module; no clocked divider is used.

Verification (bench uses CLK_DIV=8, BLANK_CYC=2)
REQ-031 Reset mid-scan: assert reset_i at slot 3, count 5 -> an_o = 3F and seg_o = 7F in the same cycle; after release, frame_o first pulses 48 cycles later.
REQ-032 Basic display: hour=12, min=34, sec=56 held -> the next frame shows digit 5..0 = 1,2,3,4,5,6 (seg_o for 1 = 7'b1111001); dp_o is low on digits 2 and 4.
REQ-033 Tearing: change sec_i from 56 to 57 during digit 2 -> digits 0 and 1 still show 5,6 until after the next frame_o, then show 5,7.
REQ-034 Illegal values: min_i=60, hour_i=31 -> digits 2..5 show the dash (7'b0111111) and the seconds digits display normally.
REQ-035 Blanking: an_o = 3F at counts 0..1 of every slot; blank_i=1 for 20 cycles keeps an_o = 3F, and frame_o still pulses every 48 cycles.
REQ-036 Wrap: feed 23:59:59 then 0:00:00 -> the consecutive frames show 2,3,5,9,5,9 and then 0,0,0,0,0,0.
